// File: rtl/clock_pkg.sv
// Shared state encoding, field-select codes and BCD limits for the set-mode clock.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package clock_pkg;

    // Encodings line up with the field_sel codes so the mapping stays obvious.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        S_HOUR = 2'd1,
        S_MIN  = 2'd2,
        S_SEC  = 2'd3
    } state_t;

    localparam logic [1:0] FSEL_NONE = 2'd0;
    localparam logic [1:0] FSEL_HOUR = 2'd1;
    localparam logic [1:0] FSEL_MIN  = 2'd2;
    localparam logic [1:0] FSEL_SEC  = 2'd3;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Two BCD digits (value <= 23) to binary. Widened to 5 bits before the
    // multiply so 2*10 does not overflow a 4-bit intermediate.
    function automatic logic [4:0] hour_to_bin(input logic [3:0] tens,
                                               input logic [3:0] units);
        return ({1'b0, tens} * 5'd10) + {1'b0, units};
    endfunction

    // Binary 0..23 to {tens[1:0], units[3:0]} BCD.
    function automatic logic [5:0] bin_to_bcd2(input logic [4:0] v);
        logic [1:0] t;
        logic [4:0] u;
        if (v >= 5'd20) begin
            t = 2'd2;
            u = v - 5'd20;
        end else if (v >= 5'd10) begin
            t = 2'd1;
            u = v - 5'd10;
        end else begin
            t = 2'd0;
            u = v;
        end
        return {t, 4'(u)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter, 00..MAX, wrapping both ways; carry on inc at MAX.
// Latency: digits update one clk after inc/dec/clr; carry is combinational.
// Backpressure: none; inc and dec together are a no-op, clr has priority.
//
// Ports: clk; clr (sync clear); inc/dec (single-cycle strobes);
//        tens/units (BCD digits); carry (inc while at MAX, i.e. wrap to 00).
module bcd2_counter #(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    logic at_max;
    logic at_zero;

    assign at_max  = (tens == MAX_T) && (units == MAX_U);
    assign at_zero = (tens == 4'd0) && (units == 4'd0);
    assign carry   = inc && !dec && at_max;

    always_ff @(posedge clk) begin
        if (clr) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (inc && !dec) begin
            if (at_max) begin
                tens  <= 4'd0;
                units <= 4'd0;
            end else if (units == 4'd9) begin
                units <= 4'd0;
                tens  <= tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end else if (dec && !inc) begin
            if (at_zero) begin
                tens  <= MAX_T;
                units <= MAX_U;
            end else if (units == 4'd0) begin
                units <= 4'd9;
                tens  <= tens - 4'd1;
            end else begin
                units <= units - 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// BCD HH:MM:SS time-of-day clock with set mode (field select, up/down edit), 12/24h view.
// Latency: digits change one clk after the button edge or prescaler tick; day_pulse registered.
// Backpressure: none; buttons are edge-detected, one action per press regardless of hold.
//
// Ports: clk, reset (sync, active-high); isset (1 = set mode); nextbutton/button1/button2
//        (debounced levels: next field / increment / decrement); hour1..sec2 (BCD digits);
//        pm (internal hour >= 12); field_sel (0 none, 1 hour, 2 min, 3 sec);
//        day_pulse (one clk on the 23:59:59 -> 00:00:00 rollover while running).
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter bit HOUR_24       = 1'b1,
    parameter bit SET_SECONDS   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       isset,
    input  logic       nextbutton,
    input  logic       button1,
    input  logic       button2,
    output logic [1:0] hour1,
    output logic [3:0] hour2,
    output logic [3:0] min1,
    output logic [3:0] min2,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic       pm,
    output logic [1:0] field_sel,
    output logic       day_pulse
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    state_t state;
    state_t state_n;

    logic next_q, b1_q, b2_q;
    logic next_pr, b1_pr, b2_pr;

    logic [CNT_W-1:0] presc;
    logic             tick;

    logic editing, ed_inc, ed_dec;

    logic       sec_inc, sec_dec, sec_carry;
    logic       min_inc, min_dec, min_carry;
    logic       hour_inc, hour_dec, hour_carry;
    logic [3:0] hour_t, hour_u;
    logic [4:0] hour_bin;
    logic [4:0] hour_disp;

    // ---------------- button edge detect ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            next_q <= 1'b0;
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
        end else begin
            next_q <= nextbutton;
            b1_q   <= button1;
            b2_q   <= button2;
        end
    end

    assign next_pr = nextbutton & ~next_q;
    assign b1_pr   = button1 & ~b1_q;
    assign b2_pr   = button2 & ~b2_q;

    // ---------------- one-second prescaler ----------------
    // Gating with isset discards a tick that coincides with entering set mode.
    assign tick = (state == RUN) && !isset && (presc == LAST);

    always_ff @(posedge clk) begin
        if (reset || (state != RUN) || isset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (isset) state_n = S_HOUR;
            S_HOUR:  if (next_pr) state_n = S_MIN;
            S_MIN:   if (next_pr) state_n = SET_SECONDS ? S_SEC : S_HOUR;
            S_SEC:   if (next_pr) state_n = S_HOUR;
            default: state_n = RUN;
        endcase
        if (!isset) state_n = RUN;
    end

    always_comb begin
        field_sel = FSEL_NONE;
        case (state)
            S_HOUR:  field_sel = FSEL_HOUR;
            S_MIN:   field_sel = FSEL_MIN;
            S_SEC:   field_sel = FSEL_SEC;
            default: field_sel = FSEL_NONE;
        endcase
    end

    // ---------------- counter control ----------------
    // Edits act on the field selected before any same-cycle nextbutton advance.
    assign editing = isset && (state != RUN);
    assign ed_inc  = editing && b1_pr && !b2_pr;
    assign ed_dec  = editing && b2_pr && !b1_pr;

    // Carries only propagate on run ticks; set-mode wraps stay within the field.
    assign sec_inc  = tick || (ed_inc && (state == S_SEC));
    assign sec_dec  = ed_dec && (state == S_SEC);
    assign min_inc  = (tick && sec_carry) || (ed_inc && (state == S_MIN));
    assign min_dec  = ed_dec && (state == S_MIN);
    assign hour_inc = (tick && sec_carry && min_carry) || (ed_inc && (state == S_HOUR));
    assign hour_dec = ed_dec && (state == S_HOUR);

    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .clr   (reset),
        .inc   (sec_inc),
        .dec   (sec_dec),
        .tens  (sec1),
        .units (sec2),
        .carry (sec_carry)
    );

    bcd2_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .clr   (reset),
        .inc   (min_inc),
        .dec   (min_dec),
        .tens  (min1),
        .units (min2),
        .carry (min_carry)
    );

    bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .clr   (reset),
        .inc   (hour_inc),
        .dec   (hour_dec),
        .tens  (hour_t),
        .units (hour_u),
        .carry (hour_carry)
    );

    // Registered so it lines up with the cycle the digits first show 00:00:00.
    always_ff @(posedge clk) begin
        if (reset) begin
            day_pulse <= 1'b0;
        end else begin
            day_pulse <= tick && sec_carry && min_carry && hour_carry;
        end
    end

    // ---------------- hour display ----------------
    assign hour_bin = hour_to_bin(hour_t, hour_u);
    assign pm       = (hour_bin >= 5'd12);

    always_comb begin
        hour_disp = hour_bin;
        if (!HOUR_24) begin
            if (hour_bin == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_bin > 5'd12) begin
                hour_disp = hour_bin - 5'd12;
            end
        end
    end

    assign {hour1, hour2} = bin_to_bcd2(hour_disp);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a 24h and a 12h instance share all inputs.
// Latency: inputs change on the falling edge; outputs are sampled on the falling edge.
// Backpressure: not applicable.
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic reset, isset, nextbutton, button1, button2;

    logic [1:0] h1_24, h1_12, fs_24, fs_12;
    logic [3:0] h2_24, m1_24, m2_24, s1_24, s2_24;
    logic [3:0] h2_12, m1_12, m2_12, s1_12, s2_12;
    logic       pm_24, pm_12, dp_24, dp_12;

    always #5 clk = ~clk;

    clock_set_ctrl #(.TICKS_PER_SEC(4), .HOUR_24(1'b1), .SET_SECONDS(1'b1)) dut24 (
        .clk(clk), .reset(reset), .isset(isset), .nextbutton(nextbutton),
        .button1(button1), .button2(button2),
        .hour1(h1_24), .hour2(h2_24), .min1(m1_24), .min2(m2_24),
        .sec1(s1_24), .sec2(s2_24), .pm(pm_24), .field_sel(fs_24), .day_pulse(dp_24)
    );

    clock_set_ctrl #(.TICKS_PER_SEC(4), .HOUR_24(1'b0), .SET_SECONDS(1'b1)) dut12 (
        .clk(clk), .reset(reset), .isset(isset), .nextbutton(nextbutton),
        .button1(button1), .button2(button2),
        .hour1(h1_12), .hour2(h2_12), .min1(m1_12), .min2(m2_12),
        .sec1(s1_12), .sec2(s2_12), .pm(pm_12), .field_sel(fs_12), .day_pulse(dp_12)
    );

    typedef struct {
        string       name;
        logic [4:0]  ctl;   // {reset, isset, nextbutton, button1, button2}
        int          rep;   // number of press/release pairs
        logic [23:0] t;     // expected 24h time as BCD hex HHMMSS
        logic [1:0]  fs;
        logic [7:0]  h12;   // expected 12h hour digits as BCD hex
        logic        pm;
    } vec_t;

    vec_t tab[$];
    int checks   = 0;
    int failures = 0;
    int dp_cnt   = 0;

    always @(posedge clk) begin
        #1;
        if (dp_24) dp_cnt++;
    end

    function automatic vec_t mk(input string nm, input logic [4:0] ctl, input int rep,
                                input logic [23:0] t, input logic [1:0] fs,
                                input logic [7:0] h12, input logic pm);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.rep = rep; v.t = t; v.fs = fs; v.h12 = h12; v.pm = pm;
        return v;
    endfunction

    function automatic logic [23:0] time24();
        return {2'b00, h1_24, h2_24, m1_24, m2_24, s1_24, s2_24};
    endfunction

    function automatic logic [23:0] time12();
        return {2'b00, h1_12, h2_12, m1_12, m2_12, s1_12, s2_12};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_row(input vec_t v);
        chk({v.name, " time"}, 32'(time24()), 32'(v.t));
        chk({v.name, " field_sel"}, 32'(fs_24), 32'(v.fs));
        chk({v.name, " pm24"}, 32'(pm_24), 32'(v.pm));
        chk({v.name, " hour12+pm"}, 32'({h1_12, h2_12, pm_12}), 32'({v.h12[5:0], v.pm}));
    endtask

    // Each repetition: drive the row for one clock, then release buttons/reset
    // (isset keeps the row value) for one clock. Checked after the last drive clock.
    task automatic apply_row(input vec_t v);
        for (int i = 0; i < v.rep; i++) begin
            {reset, isset, nextbutton, button1, button2} = v.ctl;
            @(negedge clk);
            if (i == v.rep - 1) check_row(v);
            reset = 1'b0; nextbutton = 1'b0; button1 = 1'b0; button2 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply_row(tab[i]);
    endtask

    initial begin
        // rows 0..7: set-mode editing to 11:30:55
        tab.push_back(mk("r0_reset",   5'b10000,  1, 24'h000000, 2'd0, 8'h12, 1'b0));
        tab.push_back(mk("r1_enter",   5'b01000,  1, 24'h000000, 2'd1, 8'h12, 1'b0));
        tab.push_back(mk("r2_hour_up", 5'b01010, 11, 24'h110000, 2'd1, 8'h11, 1'b0));
        tab.push_back(mk("r3_next",    5'b01100,  1, 24'h110000, 2'd2, 8'h11, 1'b0));
        tab.push_back(mk("r4_min_up",  5'b01010, 30, 24'h113000, 2'd2, 8'h11, 1'b0));
        tab.push_back(mk("r5_next",    5'b01100,  1, 24'h113000, 2'd3, 8'h11, 1'b0));
        tab.push_back(mk("r6_sec_dn",  5'b01001,  5, 24'h113055, 2'd3, 8'h11, 1'b0));
        tab.push_back(mk("r7_run",     5'b00000,  1, 24'h113055, 2'd0, 8'h11, 1'b0));
        // rows 8..22: wraps, simultaneous presses, 12h conversion
        tab.push_back(mk("t0_rst_set", 5'b11000,  1, 24'h000000, 2'd0, 8'h12, 1'b0));
        tab.push_back(mk("t1_hold",    5'b01000,  1, 24'h000000, 2'd1, 8'h12, 1'b0));
        tab.push_back(mk("t2_hr_wrap", 5'b01001,  1, 24'h230000, 2'd1, 8'h11, 1'b1));
        tab.push_back(mk("t3_both",    5'b01011,  1, 24'h230000, 2'd1, 8'h11, 1'b1));
        tab.push_back(mk("t4_next",    5'b01100,  1, 24'h230000, 2'd2, 8'h11, 1'b1));
        tab.push_back(mk("t5_mn_dn",   5'b01001,  1, 24'h235900, 2'd2, 8'h11, 1'b1));
        tab.push_back(mk("t6_mn_wrap", 5'b01010,  1, 24'h230000, 2'd2, 8'h11, 1'b1));
        tab.push_back(mk("t7_up_next", 5'b01110,  1, 24'h230100, 2'd3, 8'h11, 1'b1));
        tab.push_back(mk("t8_sc_dn",   5'b01001,  1, 24'h230159, 2'd3, 8'h11, 1'b1));
        tab.push_back(mk("t9_sc_wrap", 5'b01010,  1, 24'h230100, 2'd3, 8'h11, 1'b1));
        tab.push_back(mk("t10_next",   5'b01100,  1, 24'h230100, 2'd1, 8'h11, 1'b1));
        tab.push_back(mk("t11_hr_up",  5'b01010,  1, 24'h000100, 2'd1, 8'h12, 1'b0));
        tab.push_back(mk("t12_hr13",   5'b01001, 11, 24'h130100, 2'd1, 8'h01, 1'b1));
        tab.push_back(mk("t13_hr14",   5'b01010,  1, 24'h140100, 2'd1, 8'h02, 1'b1));
        tab.push_back(mk("t14_hr12",   5'b01001,  2, 24'h120100, 2'd1, 8'h12, 1'b1));
        // rows 23..29: set 23:59:59 for the midnight rollover
        tab.push_back(mk("m0_rst_set", 5'b11000,  1, 24'h000000, 2'd0, 8'h12, 1'b0));
        tab.push_back(mk("m1_hr23",    5'b01001,  1, 24'h230000, 2'd1, 8'h11, 1'b1));
        tab.push_back(mk("m2_next",    5'b01100,  1, 24'h230000, 2'd2, 8'h11, 1'b1));
        tab.push_back(mk("m3_mn59",    5'b01001,  1, 24'h235900, 2'd2, 8'h11, 1'b1));
        tab.push_back(mk("m4_next",    5'b01100,  1, 24'h235900, 2'd3, 8'h11, 1'b1));
        tab.push_back(mk("m5_sc59",    5'b01001,  1, 24'h235959, 2'd3, 8'h11, 1'b1));
        tab.push_back(mk("m6_run",     5'b00000,  1, 24'h235959, 2'd0, 8'h11, 1'b1));

        reset = 1'b1; isset = 1'b0; nextbutton = 1'b0; button1 = 1'b0; button2 = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("reset time24", 32'(time24()), 32'h000000);
        chk("reset time12", 32'(time12()), 32'h120000);
        chk("reset field_sel", 32'(fs_24), 32'd0);
        chk("reset pm", 32'({pm_24, pm_12}), 32'd0);
        chk("reset day_pulse", 32'({dp_24, dp_12}), 32'd0);

        // free run: one second per 4 clocks
        reset = 1'b0;
        repeat (239) @(negedge clk);
        chk("run 239cyc", 32'(time24()), 32'h000059);
        @(negedge clk);
        chk("run 240cyc", 32'(time24()), 32'h000100);
        chk("run no day_pulse", 32'(dp_cnt), 32'd0);

        // set-mode editing, then resume: first tick 4 clocks after entering RUN
        run_rows(0, 7);
        repeat (18) @(negedge clk);
        chk("resume pre-tick", 32'(time24()), 32'h113059);
        @(negedge clk);
        chk("resume 11:31:00", 32'(time24()), 32'h113100);
        chk("resume hour12", 32'(time12()), 32'h113100);

        // wraps, corner cases, 12h display
        run_rows(8, 22);

        // holding button1 for 50 clocks is a single increment
        button1 = 1'b1;
        repeat (50) @(negedge clk);
        chk("hold b1 time", 32'(time24()), 32'h130100);
        chk("hold b1 hour12+pm", 32'({h1_12, h2_12, pm_12}), 32'({6'h01, 1'b1}));
        button1 = 1'b0;
        @(negedge clk);

        // midnight rollover
        run_rows(23, 29);
        repeat (2) @(negedge clk);
        chk("midnight pre", 32'(time24()), 32'h235959);
        chk("midnight pre pulse", 32'(dp_24), 32'd0);
        @(negedge clk);
        chk("midnight time24", 32'(time24()), 32'h000000);
        chk("midnight time12", 32'(time12()), 32'h120000);
        chk("midnight pulse", 32'({dp_24, dp_12}), 32'b11);
        chk("midnight pm", 32'({pm_24, pm_12}), 32'd0);
        @(negedge clk);
        chk("midnight pulse drop", 32'(dp_24), 32'd0);
        chk("midnight pulse count", 32'(dp_cnt), 32'd1);

        // reset mid-set returns to RUN at 00:00:00 on the next clock
        isset = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre-reset field_sel", 32'(fs_24), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid-set reset time", 32'(time24()), 32'h000000);
        chk("mid-set reset field_sel", 32'(fs_24), 32'd0);
        reset = 1'b0; isset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
